// File: rtl/lcd_read_timing.sv
// ---------------------------------------------------------------------------
// lcd_read_timing
//   Read-side timing generator for an HD44780 panel in 4-bit mode. Performs
//   one 8-bit read as two nibble cycles (high nibble first) with RW high.
//   In poll mode, busy-flag reads repeat until BF=0 or MAX_POLLS bytes have
//   been read.
//
// Ports
//   i_clk, i_rst_n   system clock / asynchronous active-low reset
//   i_start          begin a read (sampled only in IDLE)
//   i_rs             register select for a single read (forced 0 in poll mode)
//   i_poll           sampled with i_start; 1 = busy-flag poll mode
//   o_busy           operation in progress
//   o_done           one-clock completion pulse
//   o_rd_data        last byte read {first nibble, second nibble}
//   o_timeout        valid with o_done; poll limit hit with BF still set
//   i_lcd_data_in    D4-D7 pin inputs (asynchronous)
//   o_lcd_rs/rw/e    LCD control pins
// ---------------------------------------------------------------------------
module lcd_read_timing #(
   parameter int SETUP_CYCLES  = 5,
   parameter int ENABLE_CYCLES = 14,
   parameter int HOLD_CYCLES   = 6,
   parameter int MAX_POLLS     = 1000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_rs,
   input  logic       i_poll,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_rd_data,
   output logic       o_timeout,
   input  logic [3:0] i_lcd_data_in,
   output logic       o_lcd_rs,
   output logic       o_lcd_rw,
   output logic       o_lcd_e
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_E_HIGH, S_E_LOW, S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_nib;        // 0 = high nibble, 1 = low nibble
   logic        r_poll_mode;
   logic [15:0] r_poll_cnt;
   logic [7:0]  r_byte;
   logic [3:0]  r_sync1;
   logic [3:0]  r_sync2;

   // Pin data is asynchronous to i_clk; two flops before use.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 4'h0;
         r_sync2 <= 4'h0;
      end else begin
         r_sync1 <= i_lcd_data_in;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_nib       <= 1'b0;
         r_poll_mode <= 1'b0;
         r_poll_cnt  <= 16'd0;
         r_byte      <= 8'h00;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_rd_data   <= 8'h00;
         o_timeout   <= 1'b0;
         o_lcd_rs    <= 1'b0;
         o_lcd_rw    <= 1'b0;
         o_lcd_e     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_lcd_e  <= 1'b0;
               o_lcd_rw <= 1'b0;
               o_busy   <= 1'b0;
               if (i_start) begin
                  o_lcd_rs    <= i_rs & ~i_poll;
                  o_lcd_rw    <= 1'b1;
                  o_busy      <= 1'b1;
                  r_poll_mode <= i_poll;
                  r_nib       <= 1'b0;
                  r_poll_cnt  <= 16'd1;
                  r_cnt       <= 8'd0;
                  r_state     <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (r_cnt == 8'(SETUP_CYCLES - 1)) begin
                  r_cnt   <= 8'd0;
                  o_lcd_e <= 1'b1;
                  r_state <= S_E_HIGH;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_E_HIGH: begin
               if (r_cnt == 8'(ENABLE_CYCLES - 1)) begin
                  // Synchronized value reflects the pins ~12 clocks after E rose.
                  if (!r_nib) r_byte[7:4] <= r_sync2;
                  else        r_byte[3:0] <= r_sync2;
                  r_cnt   <= 8'd0;
                  o_lcd_e <= 1'b0;
                  r_state <= S_E_LOW;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_E_LOW: begin
               if (r_cnt == 8'(HOLD_CYCLES - 1)) begin
                  r_cnt <= 8'd0;
                  if (!r_nib) begin
                     r_nib   <= 1'b1;
                     r_state <= S_SETUP;
                  end else if (!r_poll_mode || !r_byte[7] ||
                               (r_poll_cnt == 16'(MAX_POLLS))) begin
                     // Byte complete: publish result and release the bus.
                     o_done    <= 1'b1;
                     o_busy    <= 1'b0;
                     o_rd_data <= r_byte;
                     o_timeout <= r_poll_mode & r_byte[7];
                     o_lcd_rw  <= 1'b0;
                     o_lcd_rs  <= 1'b0;
                     r_state   <= S_DONE;
                  end else begin
                     r_poll_cnt <= r_poll_cnt + 16'd1;
                     r_nib      <= 1'b0;
                     r_state    <= S_SETUP;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end

            S_DONE: begin
               o_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/lcd_read_timing.md
Name: lcd_read_timing

Overview:
- Read-side companion to the HD44780 4-bit write timing generator.
- Performs a complete 8-bit read from the LCD as two nibble cycles (high nibble first) with RW high.
- Supports RS=0 (busy flag + address counter) and RS=1 (DDRAM/CGRAM data) reads.
- Optional poll mode repeats busy-flag reads until BF=0 or a poll limit expires, so the LCD controller can replace fixed delays.
- Sits beside the write generator under the LCD controller. The top level muxes lcd_rs/lcd_e and tri-states D4-D7 whenever lcd_rw=1.

Parameters:
- SETUP_CYCLES, 5: clocks of RS/RW setup before E rises (200 ns at 25 MHz, >60 ns tAS).
- ENABLE_CYCLES, 14: clocks E held high per nibble (560 ns, >450 ns PW_EH, >360 ns tDDR).
- HOLD_CYCLES, 6: clocks E low after each nibble (240 ns). Each nibble cycle totals 25 clocks (1000 ns).
- MAX_POLLS, 1000: maximum byte reads in poll mode before timeout (about 2 ms). Range 1..65535.

Ports:
- clk  input  1  25 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a read operation; sampled only in IDLE
- rs  input  1  register select for a single read (0=BF/AC, 1=data); ignored when poll=1
- poll  input  1  sampled with start; 1 = busy-flag poll mode
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-clock completion pulse
- rd_data  output  8  last byte read, {first nibble, second nibble}
- timeout  output  1  valid with done; 1 = poll limit reached with BF still set
- lcd_data_in  input  4  D4-D7 pin inputs (asynchronous)
- lcd_rs  output  1  LCD RS
- lcd_rw  output  1  LCD RW; top level must not drive D4-D7 while high
- lcd_e  output  1  LCD Enable

Behaviour:
- Reset (asynchronous, immediate, including mid-operation): busy=0, done=0, rd_data=0x00, timeout=0, lcd_rs=0, lcd_rw=0, lcd_e=0, state=IDLE, all counters cleared. Synchronizer flops reset to 0.
- lcd_data_in passes through a 2-flop synchronizer. Sampling uses the synchronized value: the pin value captured is at least 12 clocks (480 ns) after E rise.
- States: IDLE, SETUP, E_HIGH, E_LOW, DONE. A nibble-index bit (0=high, 1=low) and a 16-bit poll counter extend the state.
- IDLE:
  - lcd_e=0, lcd_rw=0, busy=0.
  - On start: latch rs (forced 0 if poll=1) and poll mode; set lcd_rs, lcd_rw=1, busy=1; nibble=0; poll count=1; go to SETUP.
- SETUP: lcd_e=0; lcd_rs and lcd_rw held; after SETUP_CYCLES clocks go to E_HIGH.
- E_HIGH:
  - lcd_e=1 for exactly ENABLE_CYCLES clocks.
  - On the last E_HIGH clock, capture the synchronized nibble into the internal shift byte: bits 7:4 if nibble=0, bits 3:0 if nibble=1.
- E_LOW: lcd_e=0; lcd_rs and lcd_rw held for HOLD_CYCLES clocks, then:
  - If nibble=0: set nibble=1, go to SETUP.
  - If nibble=1 and not poll mode: go to DONE.
  - If nibble=1 and poll mode, with byte bit7=0: DONE, timeout=0.
  - With bit7=1 and poll count==MAX_POLLS: DONE, timeout=1.
  - Otherwise: increment poll count, set nibble=0, go to SETUP. lcd_rw stays 1 throughout.
- DONE (1 clock):
  - done=1, busy=0, rd_data=captured byte, timeout set as above; lcd_rw=0, lcd_rs=0, lcd_e=0.
  - Next state IDLE. done deasserts the following clock.
- rd_data and timeout change only in DONE and hold between operations. timeout clears to 0 on a successful or non-poll DONE.
- Latency:
  - Single read: done asserts 51 clocks after the accepting start edge; each byte takes 50 clocks.
  - Poll of N bytes: done at 50N+1.
- start while busy or in DONE is ignored, with no queuing. start is accepted in IDLE on the cycle after done.
- lcd_rw rises together with lcd_rs, before any E edge, and falls only after E has been low for HOLD_CYCLES. lcd_e is never high while lcd_rw changes.

Test Plan:
- Reset, then single read with rs=1 and pins 0xA then 0x5 (pins change during E_LOW): lcd_rw=1 for 50 clocks, two E pulses of exactly 14 clocks, done at clock 51 with rd_data=0xA5, timeout=0, lcd_rw=0 after.
- Single read with rs=0: lcd_rs=0 throughout; pins 0x3/0xC give rd_data=0x3C.
- Poll mode with MAX_POLLS=1000: model returns BF=1 (pins 0x8,0x0) for 3 bytes, then 0x0,0x7. Expect 4 byte reads, done at clock 201, rd_data=0x07, timeout=0.
- Poll mode with MAX_POLLS=4 and BF stuck at 1 (0x9,0x2): done at 201, timeout=1, rd_data=0x92. A subsequent normal read clears timeout to 0.
- start pulsed at clock 10 and 30 of an active read: ignored, exactly one done, busy unchanged.
- rst_n asserted while lcd_e=1 mid-read: lcd_e, lcd_rw, busy, done fall immediately (asynchronously), rd_data=0x00. After release a new start completes normally.
